// File: rtl/vdp_sprite_line_scheduler.sv
// Per-scanline sequencer for the sprite collision evaluator.
// Ping-pongs the two hit-list banks between the evaluator and the renderer.
module vdp_sprite_line_scheduler #(
  parameter int HIT_LIST_DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       line_start,
  input  logic [8:0] line_y,
  output logic       eval_restart,
  output logic [8:0] eval_raster_y,
  input  logic       eval_finished,
  input  logic [8:0] eval_hit_list_index,
  output logic       write_bank,
  output logic       read_bank,
  output logic [8:0] read_hit_count,
  output logic       render_start,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] overrun_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [8:0] DEPTH_LIMIT = 9'(HIT_LIST_DEPTH);

  state_t     state, state_next;
  logic [8:0] hit_count, hit_count_next;
  logic [8:0] raster_y_next;
  logic [8:0] read_hit_count_next;
  logic       write_bank_next, read_bank_next;
  logic       render_start_next, overrun_next;
  logic [7:0] overrun_count_next;
  logic       eval_restart_next, busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      eval_restart   <= 1'b0;
      eval_raster_y  <= 9'd0;
      write_bank     <= 1'b0;
      read_bank      <= 1'b1;
      read_hit_count <= 9'd0;
      hit_count      <= 9'd0;
      render_start   <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      overrun_count  <= 8'd0;
    end else begin
      state          <= state_next;
      eval_restart   <= eval_restart_next;
      eval_raster_y  <= raster_y_next;
      write_bank     <= write_bank_next;
      read_bank      <= read_bank_next;
      read_hit_count <= read_hit_count_next;
      hit_count      <= hit_count_next;
      render_start   <= render_start_next;
      busy           <= busy_next;
      overrun        <= overrun_next;
      overrun_count  <= overrun_count_next;
    end
  end

  always_comb begin
    state_next          = state;
    raster_y_next       = eval_raster_y;
    write_bank_next     = write_bank;
    read_bank_next      = read_bank;
    read_hit_count_next = read_hit_count;
    hit_count_next      = hit_count;
    render_start_next   = 1'b0;
    overrun_next        = 1'b0;
    overrun_count_next  = overrun_count;

    case (state)
      IDLE: begin
        if (line_start) begin
          if (enable) begin
            state_next    = RESTART;
            raster_y_next = line_y;
          end else begin
            read_hit_count_next = 9'd0;
            render_start_next   = 1'b1;
          end
        end
      end

      RESTART, EVAL: begin
        // A new line before finish aborts the evaluation; the renderer gets an empty list.
        if (line_start) begin
          overrun_next        = 1'b1;
          read_hit_count_next = 9'd0;
          render_start_next   = 1'b1;
          if (overrun_count != 8'hFF)
            overrun_count_next = overrun_count + 8'd1;
          if (enable) begin
            state_next    = RESTART;
            raster_y_next = line_y;
          end else begin
            state_next = IDLE;
          end
        end else if (state == RESTART) begin
          state_next = EVAL;
        end else if (eval_finished) begin
          // The index idles at 0x1FF, so anything above capacity is clamped.
          hit_count_next = (eval_hit_list_index > DEPTH_LIMIT) ? DEPTH_LIMIT
                                                               : eval_hit_list_index;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (line_start) begin
          read_bank_next      = write_bank;
          write_bank_next     = ~write_bank;
          read_hit_count_next = hit_count;
          render_start_next   = 1'b1;
          if (enable) begin
            state_next    = RESTART;
            raster_y_next = line_y;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    eval_restart_next = (state_next == RESTART);
    busy_next         = (state_next == RESTART) || (state_next == EVAL);
  end

endmodule

// File: tb/tb_vdp_sprite_line_scheduler.sv
// Directed bench for vdp_sprite_line_scheduler: normal swaps, count clamping,
// overruns with saturation, disabled lines and mid-evaluation reset.
module tb_vdp_sprite_line_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = 9'd0;
  logic       eval_restart;
  logic [8:0] eval_raster_y;
  logic       eval_finished = 1'b0;
  logic [8:0] eval_hit_list_index = 9'h1FF;
  logic       write_bank;
  logic       read_bank;
  logic [8:0] read_hit_count;
  logic       render_start;
  logic       busy;
  logic       overrun;
  logic [7:0] overrun_count;

  int passed = 0;
  int total  = 0;

  vdp_sprite_line_scheduler #(.HIT_LIST_DEPTH(256)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .line_start          (line_start),
    .line_y              (line_y),
    .eval_restart        (eval_restart),
    .eval_raster_y       (eval_raster_y),
    .eval_finished       (eval_finished),
    .eval_hit_list_index (eval_hit_list_index),
    .write_bank          (write_bank),
    .read_bank           (read_bank),
    .read_hit_count      (read_hit_count),
    .render_start        (render_start),
    .busy                (busy),
    .overrun             (overrun),
    .overrun_count       (overrun_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic ls, input logic en, input logic [8:0] y,
                               input logic fin, input logic [8:0] idx);
    line_start          = ls;
    enable              = en;
    line_y              = y;
    eval_finished       = fin;
    eval_hit_list_index = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag, input logic rst, input logic [8:0] ry,
                          input logic wb, input logic rb, input logic [8:0] rhc,
                          input logic rs, input logic bz, input logic ov,
                          input logic [7:0] ovc);
    checkOutput({tag, ".eval_restart"},   32'(eval_restart),   32'(rst));
    checkOutput({tag, ".eval_raster_y"},  32'(eval_raster_y),  32'(ry));
    checkOutput({tag, ".write_bank"},     32'(write_bank),     32'(wb));
    checkOutput({tag, ".read_bank"},      32'(read_bank),      32'(rb));
    checkOutput({tag, ".read_hit_count"}, 32'(read_hit_count), 32'(rhc));
    checkOutput({tag, ".render_start"},   32'(render_start),   32'(rs));
    checkOutput({tag, ".busy"},           32'(busy),           32'(bz));
    checkOutput({tag, ".overrun"},        32'(overrun),        32'(ov));
    checkOutput({tag, ".overrun_count"},  32'(overrun_count),  32'(ovc));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 9'h1FF);
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 9'h1FF);
    reset = 1'b0;
    checkAll("reset", 0, 9'h000, 0, 1, 9'd0, 0, 0, 0, 8'd0);

    // Normal line at y=0x020; finished flag held during RESTART must be ignored
    applyStimulus(1'b1, 1'b1, 9'h020, 1'b0, 9'h1FF);
    checkAll("start1", 1, 9'h020, 0, 1, 9'd0, 0, 1, 0, 8'd0);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'd3);
    checkAll("eval1", 0, 9'h020, 0, 1, 9'd0, 0, 1, 0, 8'd0);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'd5);
    checkAll("done1", 0, 9'h020, 0, 1, 9'd0, 0, 0, 0, 8'd0);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'd0);
    checkAll("wait1", 0, 9'h020, 0, 1, 9'd0, 0, 0, 0, 8'd0);
    applyStimulus(1'b1, 1'b1, 9'h030, 1'b0, 9'h1FF);
    checkAll("swap1", 1, 9'h030, 1, 0, 9'd5, 1, 1, 0, 8'd0);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    checkAll("eval2", 0, 9'h030, 1, 0, 9'd5, 0, 1, 0, 8'd0);

    // Empty line
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'd0);
    applyStimulus(1'b1, 1'b1, 9'h031, 1'b0, 9'h1FF);
    checkAll("empty", 1, 9'h031, 0, 1, 9'd0, 1, 1, 0, 8'd0);

    // Full line
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'h100);
    applyStimulus(1'b1, 1'b1, 9'h032, 1'b0, 9'h1FF);
    checkAll("full", 1, 9'h032, 1, 0, 9'd256, 1, 1, 0, 8'd0);

    // Index 0x1FF clamps to capacity
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'h1FF);
    applyStimulus(1'b1, 1'b1, 9'h033, 1'b0, 9'h1FF);
    checkAll("clamp", 1, 9'h033, 0, 1, 9'd256, 1, 1, 0, 8'd0);

    // Overrun from EVAL
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    applyStimulus(1'b1, 1'b1, 9'h040, 1'b0, 9'h1FF);
    checkAll("ovr1", 1, 9'h040, 0, 1, 9'd0, 1, 1, 1, 8'd1);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    checkAll("ovr1.eval", 0, 9'h040, 0, 1, 9'd0, 0, 1, 0, 8'd1);

    for (int i = 0; i < 299; i++) begin
      applyStimulus(1'b1, 1'b1, 9'(i), 1'b0, 9'h1FF);
      applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    end
    checkAll("ovr300", 0, 9'd298, 0, 1, 9'd0, 0, 1, 0, 8'd255);

    // Finish and line start together count as an overrun with no swap or capture
    applyStimulus(1'b1, 1'b1, 9'h050, 1'b1, 9'd7);
    checkAll("fin_ls", 1, 9'h050, 0, 1, 9'd0, 1, 1, 1, 8'd255);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b1, 9'd9);
    checkAll("fin9", 0, 9'h050, 0, 1, 9'd0, 0, 0, 0, 8'd255);

    // Disabled line start from DONE swaps, then drops to IDLE
    applyStimulus(1'b1, 1'b0, 9'h060, 1'b0, 9'h1FF);
    checkAll("dis1", 0, 9'h050, 1, 0, 9'd9, 1, 0, 0, 8'd255);
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 9'h1FF);
    checkAll("dis1.idle", 0, 9'h050, 1, 0, 9'd9, 0, 0, 0, 8'd255);
    applyStimulus(1'b1, 1'b0, 9'h061, 1'b0, 9'h1FF);
    checkAll("dis2", 0, 9'h050, 1, 0, 9'd0, 1, 0, 0, 8'd255);
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 9'h1FF);
    checkAll("dis2.idle", 0, 9'h050, 1, 0, 9'd0, 0, 0, 0, 8'd255);

    // Enabled start from IDLE, then reset mid-evaluation with line_start held
    applyStimulus(1'b1, 1'b1, 9'h070, 1'b0, 9'h1FF);
    checkAll("idle_en", 1, 9'h070, 1, 0, 9'd0, 0, 1, 0, 8'd255);
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 9'h080, 1'b1, 9'd4);
    checkAll("rst_mid", 0, 9'h000, 0, 1, 9'd0, 0, 0, 0, 8'd0);
    applyStimulus(1'b1, 1'b1, 9'h081, 1'b0, 9'h1FF);
    checkAll("rst_ls", 0, 9'h000, 0, 1, 9'd0, 0, 0, 0, 8'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 9'h000, 1'b0, 9'h1FF);
    checkAll("post_rst", 0, 9'h000, 0, 1, 9'd0, 0, 0, 0, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vdp_sprite_line_scheduler.md
# vdp_sprite_line_scheduler

Per-scanline sequencer for the VDP sprite raster-collision evaluator. On each line-start strobe it restarts the evaluator for the requested raster line and ping-pongs two hit-list banks, so the evaluator fills one bank while the sprite renderer consumes the other. It captures the per-line hit count and flags evaluation overruns. It sits between the raster timing generator, the collision evaluator and the sprite renderer.

## Interface
Parameters:
- `HIT_LIST_DEPTH`, default 256: hit-list capacity per bank. The count saturates at this value.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: sprite evaluation enable, sampled at `line_start`.
- `line_start` in 1: one-cycle strobe for a new evaluation slot.
- `line_y` in 9: raster line to evaluate. Valid with `line_start`.
- `eval_restart` out 1: restart strobe to the evaluator.
- `eval_raster_y` out 9: raster line held for the evaluator. Stable while evaluating.
- `eval_finished` in 1: evaluator finished flag. Level, cleared by restart.
- `eval_hit_list_index` in 9: evaluator pre-increment hit-list index.
- `write_bank` out 1: bank the evaluator writes to.
- `read_bank` out 1: bank the renderer reads from.
- `read_hit_count` out 9: number of valid entries in `read_bank`, range 0..256.
- `render_start` out 1: one-cycle strobe telling the renderer that the read bank and count are valid.
- `busy` out 1: high while an evaluation is in flight.
- `overrun` out 1: one-cycle pulse when `line_start` arrives before the evaluation finished.
- `overrun_count` out 8: saturating count of overruns.

## Operation
States: IDLE, RESTART, EVAL, DONE.
- **IDLE:**
  - `line_start` with `enable` → RESTART.
  - `line_start` with `!enable` → stay IDLE, set `read_hit_count`=0, pulse `render_start`. No swap.
- **RESTART:**
  - `eval_restart`=1 for exactly this one cycle.
  - `eval_raster_y` was latched from `line_y` on the `line_start` cycle.
  - → EVAL.
- **EVAL:**
  - On the first cycle `eval_finished`=1: `hit_count` ← `eval_hit_list_index`, clamped to `HIT_LIST_DEPTH`, then → DONE.
  - The clamp is needed because the index reads 0x1FF (-1) while empty, but at finish the index equals the number of hits.
- **DONE:** waits for `line_start`.
- **`line_start` in DONE (normal swap):**
  - `read_bank` ← `write_bank`.
  - `write_bank` ← ~`write_bank`.
  - `read_hit_count` ← `hit_count`.
  - Pulse `render_start`.
  - If `enable`, → RESTART; otherwise → IDLE.
- **`line_start` in RESTART or EVAL (overrun):**
  - Pulse `overrun`, increment `overrun_count` (saturates at 255).
  - No bank swap. `read_hit_count` ← 0. Pulse `render_start`.
  - Evaluation is aborted by re-issuing restart: → RESTART with the new `line_y` if `enable`, else → IDLE.
- `busy` = state is RESTART or EVAL.
- `eval_finished` outside EVAL is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `eval_restart`=0, `eval_raster_y`=0.
  - `write_bank`=0, `read_bank`=1.
  - `read_hit_count`=0, `hit_count`=0.
  - `render_start`=0, `busy`=0.
  - `overrun`=0, `overrun_count`=0.
- All outputs are registered.
- `line_start` at cycle T:
  - `render_start`, `overrun`, the bank swap and the new `read_hit_count` are visible at T+1.
  - `eval_restart` is high at T+1 (state RESTART during T+1).
  - `busy` is high from T+1.
- `write_bank` changes only at swap, so it is stable for the whole evaluation.
- Finish detection: `eval_finished` high at cycle F in EVAL gives state DONE and the `hit_count` update at F+1. `busy` drops at F+1.
- `line_start` in the same cycle as the first `eval_finished`: treated as an overrun. The state decision uses the registered state only.
- `reset` asserted mid-evaluation: all registers return to reset values the next cycle. No `render_start` or `overrun` pulse.
- `line_start` while `reset` is high: ignored.

## Test plan
- **Normal line:** reset; `line_start` with `line_y`=0x020 and `enable`=1.
  - `eval_restart` is high for 1 cycle at T+1 and `eval_raster_y`=0x020.
  - Drive `eval_finished` with index 5, then a second `line_start`.
  - Expect `read_bank`=0, `write_bank`=1, `read_hit_count`=5, one `render_start`.
- **Empty and full lines:** finish with index 0 → count 0. Finish with index 0x100 → count 256. Finish with index 0x1FF → clamped to 256.
- **Overrun:** `line_start` while in EVAL.
  - Expect an `overrun` pulse, `overrun_count`=1, banks unchanged, `read_hit_count`=0, `eval_restart` re-asserted with the new `line_y`.
  - Repeat 300 times → `overrun_count`=255.
- **Disabled:** `enable`=0 at `line_start` in DONE.
  - Expect a swap with the captured count, `render_start`, then IDLE with no `eval_restart`.
  - The next disabled `line_start` gives count 0 and no swap.
- **Finish and line start in the same cycle:** treated as an overrun, with no swap.
- **Mid-evaluation reset:** assert `reset` while in EVAL. All outputs return to reset values the next cycle, with no pulses.
